// File: rtl/soc_led_monitor_if.sv
// Log read port of the LED monitor: pop strobe, first-word-fall-through
// head entry and log status flags.
interface soc_led_monitor_if #(
    parameter int LED_W = 4,
    parameter int CNT_W = 16
) ();
    logic                   log_rd_en;
    logic [CNT_W+LED_W-1:0] log_rd_data;
    logic                   log_empty;
    logic                   log_full;
    logic                   log_overflow;

    // Consumer side: reads the log.
    modport master (
        output log_rd_en,
        input  log_rd_data,
        input  log_empty,
        input  log_full,
        input  log_overflow
    );

    // Monitor side: owns the log.
    modport slave (
        input  log_rd_en,
        output log_rd_data,
        output log_empty,
        output log_full,
        output log_overflow
    );
endinterface

// File: rtl/soc_led_monitor.sv
// LED bus observer: counts run cycles, time-stamps every LED change into a
// small FIFO log and settles on a PASS / FAIL / TIMEOUT verdict.
module soc_led_monitor #(
    parameter int               LED_W         = 4,
    parameter int               CNT_W         = 16,
    parameter int               MAX_CYCLES    = 200,
    parameter logic [LED_W-1:0] PASS_PATTERN  = 4'hF,
    parameter logic [LED_W-1:0] FAIL_PATTERN  = 4'h5,
    parameter int               STABLE_CYCLES = 8,
    parameter int               LOG_DEPTH     = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [LED_W-1:0] led,
    soc_led_monitor_if.slave log_if,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] change_count,
    output logic [1:0]       state,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout
);

    localparam int PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = CNT_W + LED_W;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_AT  = CNT_W'(STABLE_CYCLES);
    localparam logic [OCC_W-1:0] OCC_ZERO   = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0] OCC_ONE    = {{(OCC_W-1){1'b0}}, 1'b1};
    localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(LOG_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Registered state
    state_t           state_r;
    logic [CNT_W-1:0] settle_cnt_r;
    logic [LED_W-1:0] sig_r;
    logic             done_r;
    logic             pass_r;
    logic             fail_r;
    logic             timeout_r;
    logic [CNT_W-1:0] cycle_count_r;
    logic [CNT_W-1:0] change_count_r;
    logic [LED_W-1:0] led_prev_r;
    logic [ENT_W-1:0] mem_r [LOG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             empty_r;
    logic             full_r;
    logic             overflow_r;

    // Combinational decisions
    state_t           state_nxt_s;
    logic [CNT_W-1:0] settle_nxt_s;
    logic [LED_W-1:0] sig_nxt_s;
    logic             done_nxt_s;
    logic             pass_nxt_s;
    logic             fail_nxt_s;
    logic             timeout_nxt_s;
    logic             settle_done_s;
    logic             active_s;
    logic             change_s;
    logic             is_pattern_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [OCC_W-1:0] occ_nxt_s;

    // Classify the cycle: activity, LED change, and log push/pop/drop decisions
    always_comb begin
        active_s     = 1'b0;
        change_s     = 1'b0;
        is_pattern_s = 1'b0;
        pop_s        = 1'b0;
        push_s       = 1'b0;
        drop_s       = 1'b0;
        if ((state_r == ST_RUN) || (state_r == ST_SETTLE)) begin
            active_s = enable;
        end else begin
            active_s = 1'b0;
        end
        change_s     = active_s && (led != led_prev_r);
        is_pattern_s = (led == PASS_PATTERN) || (led == FAIL_PATTERN);
        // A pop frees the slot the push needs, so a full log still accepts
        // an entry when it is read in the same cycle.
        pop_s        = log_if.log_rd_en && !empty_r;
        push_s       = change_s && (!full_r || pop_s);
        drop_s       = change_s && full_r && !pop_s;
    end

    // Next log occupancy from the push/pop pair
    always_comb begin
        occ_nxt_s = occ_r;
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + OCC_ONE;
            2'b01:   occ_nxt_s = occ_r - OCC_ONE;
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Next state, settle counter, signature and verdict flags
    always_comb begin
        state_nxt_s   = state_r;
        settle_nxt_s  = settle_cnt_r;
        sig_nxt_s     = sig_r;
        done_nxt_s    = done_r;
        pass_nxt_s    = pass_r;
        fail_nxt_s    = fail_r;
        timeout_nxt_s = timeout_r;
        settle_done_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (active_s && is_pattern_s) begin
                    state_nxt_s  = ST_SETTLE;
                    settle_nxt_s = CNT_ONE;
                    sig_nxt_s    = led;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_SETTLE: begin
                if (!active_s) begin
                    state_nxt_s = ST_SETTLE;
                end else if (led == sig_r) begin
                    settle_nxt_s = settle_cnt_r + CNT_ONE;
                end else if (is_pattern_s) begin
                    // Jumped straight to the other signature: restart on it.
                    settle_nxt_s = CNT_ONE;
                    sig_nxt_s    = led;
                end else begin
                    state_nxt_s  = ST_RUN;
                    settle_nxt_s = CNT_ZERO;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // A completed signature outranks a coincident timeout.
        settle_done_s = active_s && (state_nxt_s == ST_SETTLE) &&
                        (settle_nxt_s == STABLE_AT);
        if (settle_done_s) begin
            state_nxt_s   = ST_DONE;
            done_nxt_s    = 1'b1;
            pass_nxt_s    = (sig_nxt_s == PASS_PATTERN);
            fail_nxt_s    = (sig_nxt_s != PASS_PATTERN);
            timeout_nxt_s = 1'b0;
        end else if (active_s && (cycle_count_r == TIMEOUT_AT)) begin
            state_nxt_s   = ST_DONE;
            done_nxt_s    = 1'b1;
            pass_nxt_s    = 1'b0;
            fail_nxt_s    = 1'b0;
            timeout_nxt_s = 1'b1;
        end else begin
            done_nxt_s = done_r;
        end
    end

    // FSM state, settle counter, latched signature and sticky verdict flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= CNT_ZERO;
            sig_r        <= {LED_W{1'b0}};
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_r       <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            settle_cnt_r <= settle_nxt_s;
            sig_r        <= sig_nxt_s;
            done_r       <= done_nxt_s;
            pass_r       <= pass_nxt_s;
            fail_r       <= fail_nxt_s;
            timeout_r    <= timeout_nxt_s;
        end
    end

    // Saturating run-cycle and change counters, advancing only on active cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_count_r  <= CNT_ZERO;
            change_count_r <= CNT_ZERO;
        end else if (active_s) begin
            if (cycle_count_r != CNT_SAT) begin
                cycle_count_r <= cycle_count_r + CNT_ONE;
            end
            if (change_s && (change_count_r != CNT_SAT)) begin
                change_count_r <= change_count_r + CNT_ONE;
            end
        end
    end

    // Previous LED value: tracks the bus in IDLE so entry into RUN logs nothing
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_prev_r <= {LED_W{1'b0}};
        end else if ((state_r == ST_IDLE) || active_s) begin
            led_prev_r <= led;
        end
    end

    // Change log: storage, wrapping pointers, occupancy, status and overflow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < LOG_DEPTH; i++) begin
                mem_r[i] <= {ENT_W{1'b0}};
            end
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            occ_r      <= OCC_ZERO;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {cycle_count_r, led};
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            occ_r   <= occ_nxt_s;
            empty_r <= (occ_nxt_s == OCC_ZERO);
            full_r  <= (occ_nxt_s == OCC_FULL);
        end
    end

    assign log_if.log_rd_data  = mem_r[rd_ptr_r];
    assign log_if.log_empty    = empty_r;
    assign log_if.log_full     = full_r;
    assign log_if.log_overflow = overflow_r;

    assign cycle_count  = cycle_count_r;
    assign change_count = change_count_r;
    assign state        = state_r;
    assign done         = done_r;
    assign pass         = pass_r;
    assign fail         = fail_r;
    assign timeout      = timeout_r;

endmodule

// File: tb/tb_soc_led_monitor.sv
// Bench for soc_led_monitor: directed scenarios plus randomized episodes,
// each cycle's expected outputs come from a behavioural model of the rules.
module tb_soc_led_monitor;

    localparam int         LED_W      = 4;
    localparam int         CNT_W      = 16;
    localparam int         MAX_CYCLES = 200;
    localparam int         STABLE     = 8;
    localparam int         DEPTH      = 8;
    localparam logic [3:0] PASS_P     = 4'hF;
    localparam logic [3:0] FAIL_P     = 4'h5;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  led    = 4'h0;
    logic [15:0] cycle_count;
    logic [15:0] change_count;
    logic [1:0]  state;
    logic        done, pass, fail, timeout;

    soc_led_monitor_if #(.LED_W(LED_W), .CNT_W(CNT_W)) log_if ();

    soc_led_monitor #(
        .LED_W(LED_W), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES),
        .PASS_PATTERN(PASS_P), .FAIL_PATTERN(FAIL_P),
        .STABLE_CYCLES(STABLE), .LOG_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .led(led),
        .log_if(log_if),
        .cycle_count(cycle_count), .change_count(change_count),
        .state(state), .done(done), .pass(pass), .fail(fail), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [1:0]  st;
        logic [15:0] cyc;
        logic [15:0] chg;
        logic        dn, ps, fl, to, ovf, emp, ful;
        logic [19:0] head;
    } snap_t;

    snap_t exp_q[$];

    // Reference model: phase 0 waiting, 1 observing, 2 finished.
    int          m_phase, m_cyc, m_chg, m_run_len, m_verdict;
    logic [3:0]  m_prev, m_sig;
    logic        m_ovf;
    logic [19:0] m_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst_n, input bit en, input logic [3:0] l, input bit rd);
        bit pop_ok;
        bit is_pat;
        if (!rst_n) begin
            m_phase = 0; m_cyc = 0; m_chg = 0; m_run_len = 0; m_verdict = 0;
            m_prev = 4'h0; m_sig = 4'h0; m_ovf = 1'b0;
            m_log.delete();
            return;
        end
        pop_ok = rd && (m_log.size() > 0);
        if (pop_ok) void'(m_log.pop_front());
        if (m_phase == 0) begin
            m_prev = l;
            if (en) m_phase = 1;
        end else if (m_phase == 1 && en) begin
            if (l != m_prev) begin
                if (m_chg < 65535) m_chg++;
                if (m_log.size() < DEPTH) m_log.push_back({m_cyc[15:0], l});
                else m_ovf = 1'b1;
            end
            // Length of the current unbroken run of one signature value.
            is_pat = (l == PASS_P) || (l == FAIL_P);
            if (!is_pat) m_run_len = 0;
            else if (m_run_len > 0 && l == m_sig) m_run_len++;
            else m_run_len = 1;
            m_sig = l;
            if (m_run_len >= STABLE) begin
                m_verdict = (l == PASS_P) ? 1 : 2;
                m_phase   = 2;
            end else if (m_cyc == MAX_CYCLES - 1) begin
                m_verdict = 3;
                m_phase   = 2;
            end
            if (m_cyc < 65535) m_cyc++;
            m_prev = l;
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.st   = (m_phase == 0) ? 2'd0 : (m_phase == 2) ? 2'd3 : (m_run_len > 0) ? 2'd2 : 2'd1;
        s.cyc  = m_cyc[15:0];
        s.chg  = m_chg[15:0];
        s.dn   = (m_phase == 2);
        s.ps   = (m_verdict == 1);
        s.fl   = (m_verdict == 2);
        s.to   = (m_verdict == 3);
        s.ovf  = m_ovf;
        s.emp  = (m_log.size() == 0);
        s.ful  = (m_log.size() == DEPTH);
        s.head = (m_log.size() > 0) ? m_log[0] : 20'h0;
        return s;
    endfunction

    // Apply one cycle of inputs and queue the outputs expected after the next edge.
    task automatic drive(input bit rst_n, input bit en, input logic [3:0] l, input bit rd);
        @(negedge clk);
        #1;
        resetn           = rst_n;
        enable           = en;
        led              = l;
        log_if.log_rd_en = rd;
        model_step(rst_n, en, l, rd);
        exp_q.push_back(model_snap());
    endtask

    task automatic reset_dut();
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        drive(1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic settle_edge();
        @(posedge clk);
        #2;
    endtask

    // Compare DUT outputs against the queued expectation after every edge.
    snap_t e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state", state, e.st);
            check("cycle_count", cycle_count, e.cyc);
            check("change_count", change_count, e.chg);
            check("done", done, e.dn);
            check("pass", pass, e.ps);
            check("fail", fail, e.fl);
            check("timeout", timeout, e.to);
            check("overflow", log_if.log_overflow, e.ovf);
            check("empty", log_if.log_empty, e.emp);
            check("full", log_if.log_full, e.ful);
            if (!e.emp) check("log_head", log_if.log_rd_data, e.head);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    logic [3:0]  l;
    logic [19:0] ent;
    logic [19:0] s1_exp [3];
    logic [3:0]  pick [8];
    bit          en_r, rd_r;

    initial begin
        log_if.log_rd_en = 1'b0;
        model_step(1'b0, 1'b0, 4'h0, 1'b0);
        s1_exp[0] = {16'd10, 4'h1};
        s1_exp[1] = {16'd15, 4'h3};
        s1_exp[2] = {16'd20, 4'hF};
        pick[0] = 4'h0; pick[1] = 4'h1; pick[2] = 4'h3; pick[3] = 4'h5;
        pick[4] = 4'hF; pick[5] = 4'hF; pick[6] = 4'h5; pick[7] = 4'hA;

        // Reset state
        reset_dut();
        check("rst_state", state, 2'd0);
        check("rst_empty", log_if.log_empty, 1'b1);
        check("rst_full", log_if.log_full, 1'b0);
        check("rst_cycles", cycle_count, 16'd0);

        // Ramp 0 -> 1 -> 3 -> F, then hold F until pass.
        for (int k = 0; k < 100; k++) begin
            if (m_phase == 2) break;
            l = (m_cyc >= 20) ? 4'hF : (m_cyc >= 15) ? 4'h3 : (m_cyc >= 10) ? 4'h1 : 4'h0;
            drive(1'b1, 1'b1, l, 1'b0);
        end
        settle_edge();
        check("s1_done", done, 1'b1);
        check("s1_pass", pass, 1'b1);
        check("s1_state", state, 2'd3);
        check("s1_cycles", cycle_count, 16'd28);
        check("s1_changes", change_count, 16'd3);
        for (int i = 0; i < 3; i++) begin
            check("s1_log", log_if.log_rd_data, s1_exp[i]);
            drive(1'b1, 1'b1, 4'hF, 1'b1);
            settle_edge();
        end
        check("s1_drained", log_if.log_empty, 1'b1);

        // Brief fail signature that breaks off, then timeout.
        reset_dut();
        for (int k = 0; k < 400; k++) begin
            if (m_phase == 2) break;
            l = (m_cyc >= 30 && m_cyc < 33) ? 4'h5 : 4'h0;
            drive(1'b1, 1'b1, l, 1'b0);
        end
        settle_edge();
        check("s2_done", done, 1'b1);
        check("s2_timeout", timeout, 1'b1);
        check("s2_pass", pass, 1'b0);
        check("s2_fail", fail, 1'b0);
        check("s2_cycles", cycle_count, 16'd200);
        check("s2_changes", change_count, 16'd2);

        // Toggle every cycle for 12 cycles with no pops: overflow, oldest 8 kept.
        reset_dut();
        drive(1'b1, 1'b1, 4'h0, 1'b0);
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, (i % 2 == 0) ? 4'h2 : 4'h0, 1'b0);
        settle_edge();
        check("s3_full", log_if.log_full, 1'b1);
        check("s3_overflow", log_if.log_overflow, 1'b1);
        check("s3_changes", change_count, 16'd12);
        for (int i = 0; i < 8; i++) begin
            ent = {i[15:0], (i % 2 == 0) ? 4'h2 : 4'h0};
            check("s3_log", log_if.log_rd_data, ent);
            drive(1'b1, 1'b0, 4'h0, 1'b1);
            settle_edge();
        end
        check("s3_empty", log_if.log_empty, 1'b1);

        // Pop and push together on a full log.
        reset_dut();
        drive(1'b1, 1'b1, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, (i % 2 == 0) ? 4'h2 : 4'h0, 1'b0);
        settle_edge();
        check("s6_full_before", log_if.log_full, 1'b1);
        drive(1'b1, 1'b1, 4'h2, 1'b1);
        settle_edge();
        check("s6_full_after", log_if.log_full, 1'b1);
        check("s6_no_overflow", log_if.log_overflow, 1'b0);
        check("s6_head", log_if.log_rd_data, {16'd1, 4'h0});
        check("s6_changes", change_count, 16'd9);

        // Pause 20 cycles in the middle of a pass signature.
        reset_dut();
        for (int k = 0; k < 34; k++) begin
            en_r = !(k >= 10 && k <= 29);
            l    = (k >= 6) ? 4'hF : 4'h0;
            drive(1'b1, en_r, l, 1'b0);
            settle_edge();
            check("s4_done_timing", done, (k == 33));
            if (k == 29) begin
                check("s4_frozen_cycles", cycle_count, 16'd9);
                check("s4_frozen_state", state, 2'd2);
            end
        end
        check("s4_pass", pass, 1'b1);
        check("s4_cycles", cycle_count, 16'd13);

        // Asynchronous reset mid-run with 3 log entries.
        reset_dut();
        drive(1'b1, 1'b1, 4'h0, 1'b0);
        drive(1'b1, 1'b1, 4'h2, 1'b0);
        drive(1'b1, 1'b1, 4'h0, 1'b0);
        drive(1'b1, 1'b1, 4'h2, 1'b0);
        drive(1'b1, 1'b1, 4'h2, 1'b0);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("s5_state", state, 2'd0);
        check("s5_cycles", cycle_count, 16'd0);
        check("s5_changes", change_count, 16'd0);
        check("s5_empty", log_if.log_empty, 1'b1);
        check("s5_flags", {done, pass, fail, timeout, log_if.log_overflow, log_if.log_full}, 6'd0);

        // Randomized episodes.
        for (int ep = 0; ep < 6; ep++) begin
            reset_dut();
            l = 4'h0;
            for (int k = 0; k < 600; k++) begin
                if (m_phase == 2) break;
                en_r = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 9) == 0) l = pick[$urandom_range(0, 7)];
                rd_r = ($urandom_range(0, 3) == 0);
                drive(1'b1, en_r, l, rd_r);
            end
            settle_edge();
            check("rand_done", done, 1'b1);
            for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, l, 1'b1);
        end

        settle_edge();
        settle_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/soc_led_monitor.md
Name: soc_led_monitor

Overview:
- Parametrised observer that watches the SoC LED output bus during simulation and emulation runs, replacing fixed-length cycle-count benches.
- Counts run cycles and time-stamps every LED change into a small FIFO log.
- Decides PASS or FAIL from a stable LED signature, or flags TIMEOUT.
- Sits beside the soc instance; its ports connect to the SoC clock and the LED bus.

Parameters:
- LED_W, 4, width of the observed LED bus
- CNT_W, 16, width of the cycle and change counters and of the time stamp
- MAX_CYCLES, 200, run-cycle budget before timeout
- PASS_PATTERN, 4'hF, LED value that signals pass (LED_W bits)
- FAIL_PATTERN, 4'h5, LED value that signals fail (LED_W bits)
- STABLE_CYCLES, 8, consecutive cycles a signature must hold; minimum 1
- LOG_DEPTH, 8, log entries; must be a power of 2

Ports:
- clk  in  1  system clock; all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- enable  in  1  run/pause control
- led  in  LED_W  SoC LED bus under observation
- log_rd_en  in  1  pop one log entry
- log_rd_data  out  CNT_W+LED_W  head entry {stamp, led}; first-word-fall-through
- log_empty  out  1  log holds no entries
- log_full  out  1  log holds LOG_DEPTH entries
- log_overflow  out  1  sticky; a change was dropped because the log was full
- cycle_count  out  CNT_W  run cycles elapsed; saturates at all-ones
- change_count  out  CNT_W  LED changes seen; saturates
- state  out  2  0 IDLE, 1 RUN, 2 SETTLE, 3 DONE
- done, pass, fail, timeout  out  1 each  final verdict flags; sticky

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - All counters, flags, log pointers and log_overflow = 0.
  - log_empty=1, log_full=0.
  - led_prev = 0.
- IDLE:
  - led_prev <= led every cycle, so no spurious change is logged on entry.
  - enable=1 moves to RUN next cycle.
- Active cycle: any cycle in RUN or SETTLE with enable=1.
  - cycle_count increments by 1.
  - led_prev <= led.
- Paused cycle: enable=0 in RUN or SETTLE.
  - Everything freezes (state, counters, led_prev, settle counter).
  - Log reads remain allowed.
- Change detection, active cycles only: a change is led != led_prev.
  - change_count increments by 1.
  - Push {cycle_count (pre-increment value), led} to the log.
  - If the log is full and not popped in the same cycle, drop the entry and set log_overflow.
- Log semantics:
  - Push and pop in the same cycle on a full log: both succeed.
  - Pop on an empty log: ignored.
  - Pointers wrap modulo LOG_DEPTH.
  - Occupancy counter width is log2(LOG_DEPTH)+1.
- RUN -> SETTLE: on an active cycle where led equals PASS_PATTERN or FAIL_PATTERN.
  - Settle counter is set to 1.
  - The signature is latched.
- SETTLE:
  - If led equals the latched signature, the settle counter increments.
  - If led differs, return to RUN; the change is logged normally.
  - If led differs and equals the other pattern, go straight back to SETTLE with the new signature and counter=1.
- SETTLE -> DONE: when the settle counter reaches STABLE_CYCLES.
  - pass=1 if the signature is PASS_PATTERN, else fail=1.
  - done=1.
  - With STABLE_CYCLES=1, DONE follows the RUN cycle that first saw the pattern.
- Timeout: an active cycle where cycle_count == MAX_CYCLES-1 and no verdict is produced in that same cycle.
  - Move to DONE with timeout=1, done=1, pass=0, fail=0.
  - If settle completion and timeout coincide, settle completion wins.
- DONE:
  - Absorbing until reset.
  - Counters hold; enable is ignored.
  - The log stays readable.
  - Exactly one of pass, fail or timeout is 1.
- Verdict timing: flags are registered and assert in the same cycle state becomes DONE.
- Reset mid-run: immediate return to reset values; the log contents are discarded.

Test Plan:
- LED rises 0 -> 1 -> 3 -> F from cycle 10, one step per 5 cycles, then F held; enable=1 from reset release:
  - 3 changes logged with stamps 10/15/20.
  - change_count=3.
  - pass=1 at stamp 20+8, state=3.
- LED goes to 5 at cycle 30, then back to 0 at cycle 33, STABLE_CYCLES=8:
  - SETTLE then back to RUN.
  - No verdict.
  - Timeout at cycle_count=199 with done=1, pass=fail=0.
- LED toggles every cycle for 12 cycles with no pops, LOG_DEPTH=8:
  - log_full=1.
  - log_overflow=1.
  - change_count=12.
  - After 8 pops, entries hold stamps 0..7 in order.
- enable dropped for 20 cycles mid-SETTLE:
  - cycle_count and the settle counter freeze.
  - The verdict is delayed by exactly 20 cycles.
- resetn pulsed low asynchronously mid-RUN with 3 log entries:
  - All outputs immediately 0, log_empty=1, state=0.
- Simultaneous pop and push on a full log:
  - Occupancy stays 8.
  - No overflow.
  - The head advances by one.
